gb_mem_bus_resp: RTL and testbench
==================================

// Module: gb_mem_bus_resp
// PURPOSE
//  Responder end of the CPU bus protocol (bus_opcode_t: IDLE/IF/WRITE/READ/IF_CB).
//  Splits each M-cycle into four T-states. Drives the external memory strobes, applies
//  wait states and a timeout, and returns read data to the core.
//  Latches fetched opcodes into the instruction register, with a CB-prefix flag.
//  Sits between the cpu_pkg-based core and the address-decoded memory/IO fabric.
// PARAMETERS
//  IR_RESET  8'h00  instruction register value after reset (NOP)
//  MAX_WAIT  8      max consecutive stall cycles at T3 before forced completion (>=1)
// PORTS
//  clk           in   1   system clock
//  rst_n         in   1   synchronous reset, active low
//  cpu_bus_op    in   3   bus_opcode_t request for the M-cycle, sampled at T1
//  cpu_addr      in   16  access address, sampled at T1
//  cpu_dout      in   8   write data from core, sampled at T1
//  cpu_din       out  8   last read/fetched byte
//  cpu_ir        out  8   instruction register
//  cpu_ir_cb     out  1   1 = cpu_ir holds a CB-page opcode
//  t_state       out  2   current T-state, 0..3 = T1..T4
//  m_done        out  1   high during T4; core advances its microstep on this edge
//  bus_timeout   out  1   one-cycle pulse when an access is force-completed
//  mem_addr      out  16  address to fabric
//  mem_wdata     out  8   write data to fabric
//  mem_rd        out  1   read strobe
//  mem_wr        out  1   write strobe
//  mem_rdata     in   8   read data from fabric
//  mem_ready     in   1   fabric ready; low at T3 inserts wait states
// BEHAVIOUR
//  - Reset (rst_n sampled low at posedge): t=0, op_q=IDLE, addr_q=0, dout_q=0,
//    cpu_din=8'hFF, cpu_ir=IR_RESET, cpu_ir_cb=0, wait_cnt=0, bus_timeout=0.
//    Outputs decoded from these: mem_rd=mem_wr=0, m_done=0. Reset mid-access aborts it.
//    No strobe is high in the cycle after the reset edge.
//  - T counter: 0->1->2->3->0 each clk. The only hold is at t=2 (stall, below).
//    An M-cycle is 4 clocks plus stall cycles.
//  - Capture: on the posedge leaving t=0, op_q/addr_q/dout_q <= cpu_bus_op/cpu_addr/cpu_dout.
//    Op codes 5..7 are stored as IDLE.
//  - Access ops: IF, READ, IF_CB, WRITE. IDLE produces no strobes and never stalls.
//  - mem_addr=addr_q and mem_wdata=dout_q at all times (hold between accesses).
//  - mem_rd = (t==1||t==2) && op_q in {IF,READ,IF_CB}.
//  - mem_wr = (t==2) && op_q==WRITE; it stays high through every stall cycle.
//  - m_done = (t==3). All outputs are registers or decodes of registers.
//    There is no combinational path from inputs to outputs.
//  - Stall: at t==2 with an access op and mem_ready==0, t holds and wait_cnt increments.
//    When wait_cnt reaches MAX_WAIT, the access is force-completed:
//    * t advances; bus_timeout pulses for 1 clk.
//    * Read ops complete with data 8'hFF.
//    * WRITE simply ends.
//  - wait_cnt clears whenever t leaves 2.
//  - Completion edge (posedge leaving t=2, ready or forced):
//    * READ: cpu_din <= data.
//    * IF: cpu_din <= data, cpu_ir <= data, cpu_ir_cb <= 0.
//    * IF_CB: cpu_din <= data, cpu_ir <= data, cpu_ir_cb <= 1.
//    * WRITE/IDLE: cpu_din, cpu_ir, cpu_ir_cb unchanged.
//  - data is mem_rdata, or 8'hFF when forced.
//  - mem_ready is ignored outside t==2 and for IDLE.
//  - Back-to-back M-cycles need no gap cycles: a new request is captured in the T1 that
//    follows T4.
// TESTING
//  1. Hold rst_n=0 for 3 clks -> t_state=0, cpu_ir=00, cpu_ir_cb=0, cpu_din=FF,
//     mem_rd=mem_wr=m_done=0.
//  2. IF @0x0100, mem_rdata=3E, ready=1 -> mem_rd high exactly at t=1,2, mem_addr=0100.
//     cpu_ir=3E and ir_cb=0 after the t=2 edge; m_done 4th clk.
//  3. IF_CB @0x0151, data 37 -> cpu_ir=37, ir_cb=1. Following IF with data 00 ->
//     ir_cb=0, cpu_ir=00.
//  4. WRITE @0xFF80, dout 5A -> mem_wr high one clk (t=2), mem_wdata=5A, mem_rd never high.
//     cpu_din unchanged.
//  5. READ @0xC000, ready low 3 clks then data 99 -> M-cycle = 7 clks.
//     cpu_din=99, cpu_ir unchanged, no timeout.
//  6. READ with ready held low, MAX_WAIT=8 -> bus_timeout 1 clk after 8 stalls,
//     cpu_din=FF, M-cycle = 12 clks.
//     Separately: rst_n low during t=2 of WRITE -> mem_wr=0 next clk, t_state=0.

Source files
------------

// File: rtl/gb_mem_bus_resp.sv
// gb_mem_bus_resp
//   Responder end of the CPU bus. Each M-cycle is split into four T-states
//   (T1..T4 = t_state 0..3). The request is captured at T1, memory strobes
//   are driven during T2/T3, wait states are inserted at T3 while the fabric
//   is not ready, and an access that stalls too long is force-completed with
//   a one-cycle bus_timeout pulse. Fetched opcodes are latched into the
//   instruction register together with a CB-page flag.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   cpu_bus_op[2:0]     request opcode (IDLE/IF/WRITE/READ/IF_CB), sampled at T1
//   cpu_addr[15:0]      access address, sampled at T1
//   cpu_dout[7:0]       write data from the core, sampled at T1
//   cpu_din[7:0]        last read/fetched byte
//   cpu_ir[7:0]         instruction register
//   cpu_ir_cb           cpu_ir holds a CB-page opcode
//   t_state[1:0]        current T-state
//   m_done              high during T4
//   bus_timeout         one-cycle pulse when an access is force-completed
//   mem_addr[15:0]      address to fabric
//   mem_wdata[7:0]      write data to fabric
//   mem_rd, mem_wr      read / write strobes
//   mem_rdata[7:0]      read data from fabric
//   mem_ready           fabric ready, only looked at during T3 of an access
module gb_mem_bus_resp #(
  parameter logic [7:0] IR_RESET = 8'h00,
  parameter int         MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  cpu_bus_op,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic [7:0]  cpu_ir,
  output logic        cpu_ir_cb,
  output logic [1:0]  t_state,
  output logic        m_done,
  output logic        bus_timeout,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready
);

  localparam logic [2:0] OP_IDLE  = 3'd0;
  localparam logic [2:0] OP_IF    = 3'd1;
  localparam logic [2:0] OP_WRITE = 3'd2;
  localparam logic [2:0] OP_READ  = 3'd3;
  localparam logic [2:0] OP_IF_CB = 3'd4;

  localparam int WCW = $clog2(MAX_WAIT + 1);

  logic [1:0]     t_q;
  logic [2:0]     op_q;
  logic [15:0]    addr_q;
  logic [7:0]     dout_q;
  logic [WCW-1:0] wait_cnt;

  logic is_read_op;
  logic is_access;
  logic stall;
  logic force_done;
  logic hold;
  logic complete;

  // Undefined opcodes behave exactly like IDLE.
  function automatic logic [2:0] legal_op(input logic [2:0] op);
    return (op > OP_IF_CB) ? OP_IDLE : op;
  endfunction

  // A forced completion returns an open-bus value instead of fabric data.
  function automatic logic [7:0] read_data(input logic forced, input logic [7:0] rdata);
    return forced ? 8'hFF : rdata;
  endfunction

  always_comb begin
    is_read_op = (op_q == OP_IF) || (op_q == OP_READ) || (op_q == OP_IF_CB);
    is_access  = is_read_op || (op_q == OP_WRITE);
    stall      = (t_q == 2'd2) && is_access && !mem_ready;
    force_done = stall && (wait_cnt == WCW'(MAX_WAIT));
    hold       = stall && !force_done;
    complete   = (t_q == 2'd2) && !hold;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t_q         <= 2'd0;
      op_q        <= OP_IDLE;
      addr_q      <= 16'h0000;
      dout_q      <= 8'h00;
      cpu_din     <= 8'hFF;
      cpu_ir      <= IR_RESET;
      cpu_ir_cb   <= 1'b0;
      wait_cnt    <= '0;
      bus_timeout <= 1'b0;
    end else begin
      bus_timeout <= force_done;

      if (!hold) t_q <= t_q + 2'd1;

      // Counter is only ever non-zero while parked in T3.
      if (hold) wait_cnt <= wait_cnt + 1'b1;
      else      wait_cnt <= '0;

      // T1 -> T2: capture the request
      if (t_q == 2'd0) begin
        op_q   <= legal_op(cpu_bus_op);
        addr_q <= cpu_addr;
        dout_q <= cpu_dout;
      end

      // T3 -> T4: completion, ready or forced
      if (complete && is_read_op) begin
        cpu_din <= read_data(force_done, mem_rdata);
        if (op_q != OP_READ) begin
          cpu_ir    <= read_data(force_done, mem_rdata);
          cpu_ir_cb <= (op_q == OP_IF_CB);
        end
      end
    end
  end

  assign t_state   = t_q;
  assign m_done    = (t_q == 2'd3);
  assign mem_addr  = addr_q;
  assign mem_wdata = dout_q;
  assign mem_rd    = ((t_q == 2'd1) || (t_q == 2'd2)) && is_read_op;
  assign mem_wr    = (t_q == 2'd2) && (op_q == OP_WRITE);

endmodule

// File: tb/tb_gb_mem_bus_resp.sv
// Bench for gb_mem_bus_resp: directed M-cycles with hand-computed expected
// results pushed into a queue; a monitor measures each M-cycle and compares
// when m_done is seen.
module tb_gb_mem_bus_resp;

  localparam logic [2:0] OP_IDLE  = 3'd0;
  localparam logic [2:0] OP_IF    = 3'd1;
  localparam logic [2:0] OP_WRITE = 3'd2;
  localparam logic [2:0] OP_READ  = 3'd3;
  localparam logic [2:0] OP_IF_CB = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  cpu_bus_op = OP_IDLE;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_dout = 8'h00;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_ir;
  logic        cpu_ir_cb;
  logic [1:0]  t_state;
  logic        m_done;
  logic        bus_timeout;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_ready = 1'b1;

  gb_mem_bus_resp #(.IR_RESET(8'h00), .MAX_WAIT(8)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_bus_op(cpu_bus_op), .cpu_addr(cpu_addr),
    .cpu_dout(cpu_dout), .cpu_din(cpu_din), .cpu_ir(cpu_ir), .cpu_ir_cb(cpu_ir_cb),
    .t_state(t_state), .m_done(m_done), .bus_timeout(bus_timeout),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] addr;
    logic [7:0]  dout;
    logic [7:0]  rdata;
    int          nstall;
    logic [7:0]  e_din;
    logic [7:0]  e_ir;
    logic        e_cb;
    logic        e_tmo;
    int          e_len;
    int          e_rd;
    int          e_wr;
  } vec_t;

  typedef struct {
    int          id;
    logic [7:0]  din;
    logic [7:0]  ir;
    logic        cb;
    int          tmo;
    int          len;
    int          rd;
    int          wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[12];

  int total = 0;
  int bad = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: measure each M-cycle, compare against the queue head at T4.
  int len = 0, rdc = 0, wrc = 0, tmoc = 0;
  logic [15:0] seen_addr = 16'h0;
  logic [7:0]  seen_wd = 8'h0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n || !mon_en) begin
      len = 0; rdc = 0; wrc = 0; tmoc = 0;
    end else begin
      len++;
      rdc  += int'(mem_rd);
      wrc  += int'(mem_wr);
      tmoc += int'(bus_timeout);
      if (mem_rd || mem_wr) begin
        seen_addr = mem_addr;
        seen_wd   = mem_wdata;
      end
      if (m_done) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_m_done actual=1 required=0");
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("v%0d_din", e.id), 32'(cpu_din), 32'(e.din));
          chk($sformatf("v%0d_ir", e.id), 32'(cpu_ir), 32'(e.ir));
          chk($sformatf("v%0d_ir_cb", e.id), 32'(cpu_ir_cb), 32'(e.cb));
          chk($sformatf("v%0d_timeout", e.id), 32'(tmoc), 32'(e.tmo));
          chk($sformatf("v%0d_len", e.id), 32'(len), 32'(e.len));
          chk($sformatf("v%0d_rd_cycles", e.id), 32'(rdc), 32'(e.rd));
          chk($sformatf("v%0d_wr_cycles", e.id), 32'(wrc), 32'(e.wr));
          if (e.rd + e.wr > 0)
            chk($sformatf("v%0d_addr", e.id), 32'(seen_addr), 32'(e.addr));
          if (e.wr > 0)
            chk($sformatf("v%0d_wdata", e.id), 32'(seen_wd), 32'(e.wdata));
        end
        len = 0; rdc = 0; wrc = 0; tmoc = 0;
      end
    end
  end

  // Called at a negedge where t_state is 0; returns at the next T1 negedge.
  task automatic mcycle(input int id);
    vec_t v;
    exp_t e;
    int st;
    bit ended;
    v = vecs[id];
    chk($sformatf("v%0d_start_t", id), 32'(t_state), 32'd0);
    cpu_bus_op = v.op;
    cpu_addr   = v.addr;
    cpu_dout   = v.dout;
    mem_rdata  = v.rdata;
    mem_ready  = 1'b1;
    e.id = id; e.din = v.e_din; e.ir = v.e_ir; e.cb = v.e_cb;
    e.tmo = int'(v.e_tmo); e.len = v.e_len; e.rd = v.e_rd; e.wr = v.e_wr;
    e.addr = v.addr; e.wdata = v.dout;
    exp_q.push_back(e);
    st = 0;
    ended = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (t_state == 2'd2) begin
        mem_ready = (st >= v.nstall);
        st++;
      end else begin
        ended = 1'b1;
        break;
      end
    end
    if (!ended) begin
      total++; bad++;
      $display("FAIL v%0d_stall_bound actual=stuck required=complete", id);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          op        addr     dout   rdata  nst  din    ir     cb    tmo   len rd wr
    vecs[0]  = '{OP_IF,    16'h0100, 8'h00, 8'h3E, 0,   8'h3E, 8'h3E, 1'b0, 1'b0, 4,  2, 0};
    vecs[1]  = '{OP_IF_CB, 16'h0151, 8'h00, 8'h37, 0,   8'h37, 8'h37, 1'b1, 1'b0, 4,  2, 0};
    vecs[2]  = '{OP_IF,    16'h0152, 8'h00, 8'h00, 0,   8'h00, 8'h00, 1'b0, 1'b0, 4,  2, 0};
    vecs[3]  = '{OP_WRITE, 16'hFF80, 8'h5A, 8'hAA, 0,   8'h00, 8'h00, 1'b0, 1'b0, 4,  0, 1};
    vecs[4]  = '{OP_READ,  16'hC000, 8'h00, 8'h99, 3,   8'h99, 8'h00, 1'b0, 1'b0, 7,  5, 0};
    vecs[5]  = '{OP_READ,  16'hC001, 8'h00, 8'h12, 100, 8'hFF, 8'h00, 1'b0, 1'b1, 12, 10, 0};
    vecs[6]  = '{OP_IF,    16'h0200, 8'h00, 8'hC3, 2,   8'hC3, 8'hC3, 1'b0, 1'b0, 6,  4, 0};
    vecs[7]  = '{OP_IDLE,  16'h0300, 8'h11, 8'h44, 5,   8'hC3, 8'hC3, 1'b0, 1'b0, 4,  0, 0};
    vecs[8]  = '{3'd6,     16'h0301, 8'h22, 8'h55, 5,   8'hC3, 8'hC3, 1'b0, 1'b0, 4,  0, 0};
    vecs[9]  = '{OP_WRITE, 16'h8001, 8'hA5, 8'h66, 100, 8'hC3, 8'hC3, 1'b0, 1'b1, 12, 0, 9};
    vecs[10] = '{OP_IF_CB, 16'h0400, 8'h00, 8'h77, 100, 8'hFF, 8'hFF, 1'b1, 1'b1, 12, 10, 0};
    vecs[11] = '{OP_READ,  16'h1234, 8'h00, 8'h5C, 1,   8'h5C, 8'hFF, 1'b1, 1'b0, 5,  3, 0};

    // Reset held for three clocks
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_t_state", 32'(t_state), 32'd0);
    chk("rst_cpu_ir", 32'(cpu_ir), 32'h00);
    chk("rst_ir_cb", 32'(cpu_ir_cb), 32'd0);
    chk("rst_cpu_din", 32'(cpu_din), 32'hFF);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_m_done", 32'(m_done), 32'd0);
    chk("rst_timeout", 32'(bus_timeout), 32'd0);

    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) mcycle(i);

    // Reset in the middle of a WRITE strobe
    mon_en     = 1'b0;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    cpu_bus_op = OP_WRITE;
    cpu_addr   = 16'h8000;
    cpu_dout   = 8'h77;
    mem_ready  = 1'b1;
    @(negedge clk);
    chk("mrst_t1", 32'(t_state), 32'd1);
    @(negedge clk);
    chk("mrst_wr_before", 32'(mem_wr), 32'd1);
    chk("mrst_wdata", 32'(mem_wdata), 32'h77);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_wr_after", 32'(mem_wr), 32'd0);
    chk("mrst_rd_after", 32'(mem_rd), 32'd0);
    chk("mrst_t_state", 32'(t_state), 32'd0);
    chk("mrst_cpu_din", 32'(cpu_din), 32'hFF);
    chk("mrst_cpu_ir", 32'(cpu_ir), 32'h00);
    chk("mrst_ir_cb", 32'(cpu_ir_cb), 32'd0);
    chk("mrst_m_done", 32'(m_done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
